// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter.
// State encoding, port count and port index type.
package mem_arb_pkg;

  localparam int NUM_PORTS = 2;

  typedef logic [$clog2(NUM_PORTS)-1:0] port_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection for the arbiter.
// Fixed priority to port 0 or alternate on contention.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req_i,
  input  port_t                last_i,
  input  logic                 rr_i,
  output logic                 valid_o,
  output port_t                winner_o
);

  // Single requester wins; contention uses rr_i.
  always_comb begin
    valid_o  = |req_i;
    winner_o = port_t'(0);
    unique case (1'b1)
      (req_i == 2'b10): winner_o = port_t'(1);
      (req_i == 2'b11): winner_o = rr_i ? ~last_i
                                        : port_t'(0);
      default:          winner_o = port_t'(0);
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a 64 KiB byte memory.
// IDLE -> ACCESS -> DONE, back-to-back from DONE.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ROUND_ROBIN = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [15:0] p0_addr,
  input  logic [7:0]  p0_wdata,
  output logic        p0_ack,
  output logic [7:0]  p0_rdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [15:0] p1_addr,
  input  logic [7:0]  p1_wdata,
  output logic        p1_ack,
  output logic [7:0]  p1_rdata,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [7:0]  mem_rdata
);

  state_e      state_q;
  port_t       gnt_q;
  port_t       last_q;
  logic [15:0] addr_q;
  logic [7:0]  wdata_q;
  logic        rd_q;
  logic        wr_q;
  logic        ack0_q;
  logic        ack1_q;
  logic [7:0]  rdata0_q;
  logic [7:0]  rdata1_q;

  logic [NUM_PORTS-1:0] cand_d;
  logic                 pick_vld;
  port_t                pick_win;
  logic                 sel_we_d;
  logic [15:0]          sel_addr_d;
  logic [7:0]           sel_wdata_d;

  // Candidates: in DONE the port being acked is masked.
  always_comb begin
    cand_d = {p1_req, p0_req};
    if (state_q == DONE) cand_d[gnt_q] = 1'b0;
  end

  mem_arb_pick u_pick (
    .req_i    (cand_d),
    .last_i   (last_q),
    .rr_i     (ROUND_ROBIN != 0),
    .valid_o  (pick_vld),
    .winner_o (pick_win)
  );

  // Request fields of the selected winner.
  always_comb begin
    sel_we_d    = pick_win[0] ? p1_we    : p0_we;
    sel_addr_d  = pick_win[0] ? p1_addr  : p0_addr;
    sel_wdata_d = pick_win[0] ? p1_wdata : p0_wdata;
  end

  // FSM with latched request and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      gnt_q    <= port_t'(0);
      last_q   <= port_t'(1);
      addr_q   <= '0;
      wdata_q  <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
      unique case (state_q)
        IDLE, DONE: begin
          if (pick_vld) begin
            state_q <= ACCESS;
            gnt_q   <= pick_win;
            last_q  <= pick_win;
            addr_q  <= sel_addr_d;
            wdata_q <= sel_wdata_d;
            rd_q    <= ~sel_we_d;
            wr_q    <= sel_we_d;
          end else begin
            state_q <= IDLE;
          end
        end
        ACCESS: begin
          state_q <= DONE;
          if (gnt_q[0]) begin
            ack1_q   <= 1'b1;
            rdata1_q <= mem_rdata;
          end else begin
            ack0_q   <= 1'b1;
            rdata0_q <= mem_rdata;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign p0_ack    = ack0_q;
  assign p1_ack    = ack1_q;
  assign p0_rdata  = rdata0_q;
  assign p1_rdata  = rdata1_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_rd    = rd_q;
  assign mem_wr    = wr_q;

endmodule
